// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter for the single-port instruction ROM: fetch has priority, dbg is
// guaranteed service by a starvation counter. Optional macro ROM_ALIGN_CHECK_EN flags misaligned reads.
module rom_port_arbiter #(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 32,
   parameter int FAIR_CNT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_err,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ready,
   output logic              dbg_valid,
   output logic [DATA_W-1:0] dbg_data,
   output logic              dbg_err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_inst,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

   localparam logic [3:0] FAIR = 4'(FAIR_CNT);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;   // 1 = dbg owns the in-flight access
   logic [3:0]        starve_q, starve_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
   logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
   logic              dbg_win;
   logic [DATA_W-1:0] cap_word;
`ifdef ROM_ALIGN_CHECK_EN
   logic              err_q, err_d;
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_d     = starve_q;
      rom_addr_d   = rom_addr_q;
      fetch_data_d = fetch_data_q;
      dbg_data_d   = dbg_data_q;
      fetch_ready  = 1'b0;
      dbg_ready    = 1'b0;
      fetch_valid  = 1'b0;
      dbg_valid    = 1'b0;
      fetch_err    = 1'b0;
      dbg_err      = 1'b0;
      dbg_win      = dbg_req && (!fetch_req || (starve_q == FAIR));
      cap_word     = rom_inst;
`ifdef ROM_ALIGN_CHECK_EN
      err_d        = err_q;
      if (err_q) cap_word = '0;
`endif
      case (state_q)
         IDLE: begin
            if (fetch_req || dbg_req) begin
               state_d = READ;
               owner_d = dbg_win;
               if (dbg_win) begin
                  dbg_ready  = 1'b1;
                  rom_addr_d = dbg_addr;
                  starve_d   = 4'd0;
               end else begin
                  fetch_ready = 1'b1;
                  rom_addr_d  = fetch_addr;
                  // Count only grants that made a waiting dbg request lose.
                  if (dbg_req)
                     starve_d = (starve_q == FAIR) ? starve_q : starve_q + 4'd1;
                  else
                     starve_d = 4'd0;
               end
`ifdef ROM_ALIGN_CHECK_EN
               err_d = dbg_win ? (dbg_addr[1:0] != 2'b00) : (fetch_addr[1:0] != 2'b00);
`endif
            end
         end
         READ: begin
            state_d = RESP;
            if (owner_q) dbg_data_d   = cap_word;
            else         fetch_data_d = cap_word;
         end
         RESP: begin
            state_d     = IDLE;
            fetch_valid = !owner_q;
            dbg_valid   = owner_q;
`ifdef ROM_ALIGN_CHECK_EN
            fetch_err   = !owner_q && err_q;
            dbg_err     = owner_q && err_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         starve_q     <= 4'd0;
         rom_addr_q   <= '0;
         fetch_data_q <= '0;
         dbg_data_q   <= '0;
`ifdef ROM_ALIGN_CHECK_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_q     <= starve_d;
         rom_addr_q   <= rom_addr_d;
         fetch_data_q <= fetch_data_d;
         dbg_data_q   <= dbg_data_d;
`ifdef ROM_ALIGN_CHECK_EN
         err_q        <= err_d;
`endif
      end
   end

   assign rom_addr   = rom_addr_q;
   assign fetch_data = fetch_data_q;
   assign dbg_data   = dbg_data_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level transaction model.
module tb_rom_port_arbiter;

   localparam int AW = 17;
   localparam int DW = 32;
   localparam int FAIR = 4;
`ifdef ROM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic          clock, reset;
   logic          fetch_req, dbg_req;
   logic [AW-1:0] fetch_addr, dbg_addr, rom_addr;
   logic          fetch_ready, fetch_valid, fetch_err;
   logic          dbg_ready, dbg_valid, dbg_err, busy;
   logic [DW-1:0] fetch_data, dbg_data, rom_inst;

   int passed = 0;
   int total  = 0;

   rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_CNT(FAIR)) dut (
      .clock(clock), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
      .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_err(dbg_err),
      .rom_addr(rom_addr), .rom_inst(rom_inst), .busy(busy)
   );

   function automatic logic [DW-1:0] rom_word(input logic [14:0] idx);
      if (idx == 15'd0) return 32'h0000_2737;
      if (idx == 15'd1) return 32'h5807_0713;
      return ({17'd0, idx} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   // Combinational ROM indexed by word address
   assign rom_inst = rom_word(rom_addr[16:2]);

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; fetch_req = 1'b0; dbg_req = 1'b0;
      fetch_addr = '0; dbg_addr = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fetch_req = 1'b0; dbg_req = 1'b0;
      fetch_addr = 17'h1FFFC; dbg_addr = 17'h1FFFC;
      tick(); tick();
      total++;
      if ({fetch_ready, fetch_valid, fetch_err, dbg_ready, dbg_valid, dbg_err, busy} !== 7'b0)
         $display("FAIL reset_flags got=%b want=0000000",
                  {fetch_ready, fetch_valid, fetch_err, dbg_ready, dbg_valid, dbg_err, busy});
      else passed++;
      total++;
      if (rom_addr !== '0 || fetch_data !== '0 || dbg_data !== '0)
         $display("FAIL reset_regs rom_addr=%h fetch_data=%h dbg_data=%h want all 0", rom_addr, fetch_data, dbg_data);
      else passed++;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({fetch_ready, fetch_valid, dbg_ready, dbg_valid, busy} !== 5'b0)
            $display("FAIL idle_quiet cycle=%0d got=%b want=00000", i,
                     {fetch_ready, fetch_valid, dbg_ready, dbg_valid, busy});
         else passed++;
      end
      $display("test_reset done: %0d/%0d", passed, total);
   endtask

   task automatic test_single_fetch();
      do_reset();
      fetch_req = 1'b1; fetch_addr = 17'h00004;
      #1;
      total++;
      if (fetch_ready !== 1'b1 || dbg_ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL single_T fetch_ready=%b dbg_ready=%b busy=%b want 1 0 0", fetch_ready, dbg_ready, busy);
      else passed++;
      tick();
      fetch_req = 1'b0;
      #1;
      total++;
      if (rom_addr !== 17'h00004 || busy !== 1'b1 || fetch_valid !== 1'b0 || fetch_ready !== 1'b0)
         $display("FAIL single_T1 rom_addr=%h busy=%b valid=%b ready=%b want 00004 1 0 0",
                  rom_addr, busy, fetch_valid, fetch_ready);
      else passed++;
      tick();
      total++;
      if (fetch_valid !== 1'b1 || fetch_data !== 32'h5807_0713 || busy !== 1'b1 || dbg_valid !== 1'b0)
         $display("FAIL single_T2 valid=%b data=%h busy=%b dbg_valid=%b want 1 58070713 1 0",
                  fetch_valid, fetch_data, busy, dbg_valid);
      else passed++;
      tick();
      total++;
      if (fetch_valid !== 1'b0 || busy !== 1'b0 || fetch_data !== 32'h5807_0713)
         $display("FAIL single_T3 valid=%b busy=%b data=%h want 0 0 58070713", fetch_valid, busy, fetch_data);
      else passed++;
      $display("test_single_fetch done: %0d/%0d", passed, total);
   endtask

   task automatic test_fairness();
      logic exp_dbg;
      do_reset();
      fetch_req = 1'b1; fetch_addr = 17'h00010;
      dbg_req   = 1'b1; dbg_addr   = 17'h00020;
      for (int i = 0; i < 30; i++) begin
         #1;
         // Grant pattern repeats every 5 grants: four fetches, then dbg
         exp_dbg = ((i / 3) % 5) == 4;
         total++;
         if (fetch_ready !== ((i % 3 == 0) && !exp_dbg) || dbg_ready !== ((i % 3 == 0) && exp_dbg))
            $display("FAIL fair_ready cycle=%0d fetch_ready=%b dbg_ready=%b want %b %b", i,
                     fetch_ready, dbg_ready, (i % 3 == 0) && !exp_dbg, (i % 3 == 0) && exp_dbg);
         else passed++;
         total++;
         if (fetch_valid !== ((i % 3 == 2) && !exp_dbg) || dbg_valid !== ((i % 3 == 2) && exp_dbg))
            $display("FAIL fair_valid cycle=%0d fetch_valid=%b dbg_valid=%b want %b %b", i,
                     fetch_valid, dbg_valid, (i % 3 == 2) && !exp_dbg, (i % 3 == 2) && exp_dbg);
         else passed++;
         if (i % 3 == 2) begin
            total++;
            if (exp_dbg ? (dbg_data !== rom_word(15'd8)) : (fetch_data !== rom_word(15'd4)))
               $display("FAIL fair_data cycle=%0d fetch_data=%h dbg_data=%h want %h", i,
                        fetch_data, dbg_data, exp_dbg ? rom_word(15'd8) : rom_word(15'd4));
            else passed++;
         end
         tick();
      end
      fetch_req = 1'b0; dbg_req = 1'b0;
      $display("test_fairness done: %0d/%0d", passed, total);
   endtask

   task automatic test_withdraw();
      do_reset();
      fetch_req = 1'b1; fetch_addr = 17'h00008;
      #1;
      total++;
      if (fetch_ready !== 1'b1) $display("FAIL withdraw_grant fetch_ready=%b want 1", fetch_ready);
      else passed++;
      tick();
      fetch_req = 1'b0; dbg_req = 1'b1; dbg_addr = 17'h00040;
      #1;
      total++;
      if (dbg_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL withdraw_read dbg_ready=%b busy=%b want 0 1", dbg_ready, busy);
      else passed++;
      tick();
      dbg_req = 1'b0;
      for (int j = 0; j < 8; j++) begin
         #1;
         total++;
         if (dbg_ready !== 1'b0 || dbg_valid !== 1'b0 || fetch_valid !== (j == 0))
            $display("FAIL withdraw_after cycle=%0d dbg_ready=%b dbg_valid=%b fetch_valid=%b want 0 0 %b",
                     j, dbg_ready, dbg_valid, fetch_valid, j == 0);
         else passed++;
         tick();
      end
      $display("test_withdraw done: %0d/%0d", passed, total);
   endtask

   task automatic test_reset_midop();
      do_reset();
      fetch_req = 1'b1; fetch_addr = 17'h00004;
      tick();
      fetch_req = 1'b0;
      tick(); tick();
      total++;
      if (fetch_data !== 32'h5807_0713) $display("FAIL midop_pre data=%h want 58070713", fetch_data);
      else passed++;
      fetch_req = 1'b1; fetch_addr = 17'h00008;
      #1;
      total++;
      if (fetch_ready !== 1'b1) $display("FAIL midop_grant fetch_ready=%b want 1", fetch_ready);
      else passed++;
      tick();
      fetch_req = 1'b0; reset = 1'b1;
      #1;
      total++;
      if (busy !== 1'b1 || rom_addr !== 17'h00008)
         $display("FAIL midop_read busy=%b rom_addr=%h want 1 00008", busy, rom_addr);
      else passed++;
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || fetch_valid !== 1'b0 || fetch_data !== '0 || rom_addr !== '0)
         $display("FAIL midop_after busy=%b valid=%b data=%h rom_addr=%h want 0 0 0 0",
                  busy, fetch_valid, fetch_data, rom_addr);
      else passed++;
      for (int j = 0; j < 3; j++) begin
         tick();
         total++;
         if (fetch_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midop_quiet cycle=%0d valid=%b busy=%b want 0 0", j, fetch_valid, busy);
         else passed++;
      end
      $display("test_reset_midop done: %0d/%0d", passed, total);
   endtask

   task automatic test_align();
      logic [DW-1:0] exp_data;
      exp_data = ALIGN_EN ? 32'h0 : 32'h5807_0713;
      do_reset();
      dbg_req = 1'b1; dbg_addr = 17'h00006;
      #1;
      total++;
      if (dbg_ready !== 1'b1) $display("FAIL align_grant dbg_ready=%b want 1", dbg_ready);
      else passed++;
      tick();
      dbg_req = 1'b0;
      tick();
      total++;
      if (dbg_valid !== 1'b1 || dbg_err !== ALIGN_EN || dbg_data !== exp_data || fetch_err !== 1'b0)
         $display("FAIL align_resp valid=%b err=%b data=%h fetch_err=%b want 1 %b %h 0",
                  dbg_valid, dbg_err, dbg_data, fetch_err, ALIGN_EN, exp_data);
      else passed++;
      $display("test_align done: %0d/%0d", passed, total);
   endtask

   task automatic test_random();
      int            phase;      // 0 idle, 1 rom read, 2 response
      int            starve;
      bit            own_dbg, win_f, win_d, p_err;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] exp_f, exp_d, word;
      do_reset();
      phase = 0; starve = 0; own_dbg = 0; p_addr = '0; p_err = 0;
      exp_f = '0; exp_d = '0;
      for (int c = 0; c < 900; c++) begin
         fetch_req  = ($urandom_range(0, 9) < 6);
         dbg_req    = ($urandom_range(0, 9) < 5);
         fetch_addr = 17'($urandom_range(0, 17'h1FFFF));
         dbg_addr   = 17'($urandom_range(0, 17'h1FFFF));
         if ($urandom_range(0, 3) != 0) fetch_addr[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) dbg_addr[1:0]   = 2'b00;
         if ($urandom_range(0, 15) == 0) fetch_addr = 17'h1FFFC;
         #1;
         win_f = 0; win_d = 0;
         if (phase == 0) begin
            win_d = dbg_req && (!fetch_req || starve == FAIR);
            win_f = fetch_req && !win_d;
         end
         if (phase == 2) begin
            p_err = ALIGN_EN && (p_addr[1:0] != 2'b00);
            word  = p_err ? 32'h0 : rom_word(p_addr[16:2]);
            if (own_dbg) exp_d = word; else exp_f = word;
         end
         total++;
         if (fetch_ready !== win_f || dbg_ready !== win_d || busy !== (phase != 0))
            $display("FAIL rand_ready cycle=%0d fetch_ready=%b dbg_ready=%b busy=%b want %b %b %b",
                     c, fetch_ready, dbg_ready, busy, win_f, win_d, phase != 0);
         else passed++;
         total++;
         if (fetch_valid !== (phase == 2 && !own_dbg) || dbg_valid !== (phase == 2 && own_dbg) ||
             fetch_err !== (phase == 2 && !own_dbg && p_err) || dbg_err !== (phase == 2 && own_dbg && p_err))
            $display("FAIL rand_valid cycle=%0d fv=%b dv=%b fe=%b de=%b want %b %b %b %b", c,
                     fetch_valid, dbg_valid, fetch_err, dbg_err, phase == 2 && !own_dbg,
                     phase == 2 && own_dbg, phase == 2 && !own_dbg && p_err, phase == 2 && own_dbg && p_err);
         else passed++;
         total++;
         if (fetch_data !== exp_f || dbg_data !== exp_d)
            $display("FAIL rand_data cycle=%0d fetch_data=%h dbg_data=%h want %h %h",
                     c, fetch_data, dbg_data, exp_f, exp_d);
         else passed++;
         if (phase != 0) begin
            total++;
            if (rom_addr !== p_addr)
               $display("FAIL rand_rom_addr cycle=%0d rom_addr=%h want %h", c, rom_addr, p_addr);
            else passed++;
         end
         if (phase == 0 && (win_f || win_d)) begin
            own_dbg = win_d;
            p_addr  = win_d ? dbg_addr : fetch_addr;
            if (win_d)        starve = 0;
            else if (dbg_req) starve = (starve == FAIR) ? FAIR : starve + 1;
            else              starve = 0;
            phase = 1;
         end else if (phase == 1) phase = 2;
         else phase = 0;
         tick();
      end
      fetch_req = 1'b0; dbg_req = 1'b0;
      $display("test_random done: %0d/%0d", passed, total);
   endtask

   initial begin
      reset = 1'b1; fetch_req = 1'b0; dbg_req = 1'b0;
      fetch_addr = '0; dbg_addr = '0;
      test_reset();
      test_single_fetch();
      test_fairness();
      test_withdraw();
      test_reset_midop();
      test_align();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout passed=%0d total=%0d want run to complete", passed, total);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port instruction ROM between two requesters: the processor fetch path (fetch_*) and a debug/data read path (dbg_*).
- The ROM read is combinational, indexed by address bits [16:2]. This block registers the ROM address, captures the returned word and hands it back to the winning requester with a valid pulse.
- Arbitration is fixed priority to fetch, with an anti-starvation counter so dbg is always served.

Parameters:
- ADDR_W, 17, byte-address width driven to the ROM
- DATA_W, 32, ROM word width
- FAIR_CNT, 4, max consecutive fetch grants while dbg_req is pending before dbg is forced to win (range 1..15)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch read request; held with address until fetch_ready
- fetch_addr  in  ADDR_W  fetch byte address
- fetch_ready  out  1  request accepted this cycle (combinational, IDLE only)
- fetch_valid  out  1  one-cycle pulse: fetch_data is valid
- fetch_data  out  DATA_W  returned word, held until next capture
- fetch_err  out  1  alignment error, qualified by fetch_valid
- dbg_req  in  1  debug read request; same rules as fetch_req
- dbg_addr  in  ADDR_W  debug byte address
- dbg_ready  out  1  debug request accepted this cycle
- dbg_valid  out  1  one-cycle pulse: dbg_data is valid
- dbg_data  out  DATA_W  returned word
- dbg_err  out  1  alignment error, qualified by dbg_valid
- rom_addr  out  ADDR_W  registered address to the ROM addr input
- rom_inst  in  DATA_W  ROM Inst output
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE
  - rom_addr=0
  - fetch_data=dbg_data=0
  - all valid/ready/err outputs=0
  - owner=fetch
  - starve_cnt=0
- FSM states are IDLE, READ and RESP, visited IDLE -> READ -> RESP -> IDLE. There is one access per 3 cycles; no back-to-back acceptance.
- IDLE arbitration:
  - Winner selection:
    - Only fetch_req high: fetch wins.
    - Only dbg_req high: dbg wins.
    - Both high: dbg wins if starve_cnt==FAIR_CNT, else fetch wins.
  - Winner's ready=1 combinationally.
  - rom_addr <= winner addr; owner <= winner; state <= READ.
  - No request: stay in IDLE, no ready.
- starve_cnt update at each grant:
  - Fetch granted while dbg_req high: starve_cnt+1, saturating at FAIR_CNT.
  - dbg granted, or fetch granted with dbg_req low: starve_cnt=0.
- READ: rom_addr stable. At the clock edge, capture rom_inst into the owner's data register; state <= RESP.
- RESP: owner's valid=1 for exactly this cycle; state <= IDLE.
- Latency: ready at cycle T, valid at T+2, next acceptance earliest at T+3.
- The non-owner's data register and valid are untouched during an access.
- Requesters may drop req before ready: no effect, nothing is latched. After ready, req/addr changes do not affect the in-flight access.
- Only ADDR_W bits are used, so there is no address wrap logic. Address 0x1FFFC is legal.
- Reset during READ or RESP: the access is aborted and no valid is issued.

Optional Feature:
- Macro: ROM_ALIGN_CHECK_EN
- Defined:
  - At IDLE grant, if winner addr[1:0]!=0, latch an error flag.
  - In READ, capture 0 instead of rom_inst.
  - In RESP, assert the owner's err together with valid.
  - Timing is unchanged.
- Undefined: addr[1:0] ignored (ROM indexes by [16:2]); fetch_err and dbg_err tied 0.

Test Plan:
- Reset then idle: bench ROM word0=0x00002737. Assert reset 2 cycles -> all outputs 0, busy=0; no req -> no ready/valid for 10 cycles.
- Single fetch: fetch_req=1, fetch_addr=0x00004 (ROM word1=0x58070713) -> fetch_ready at T, rom_addr=0x00004 at T+1, fetch_valid at T+2 with fetch_data=0x58070713, busy high T+1..T+2.
- Simultaneous reqs, FAIR_CNT=4:
  - Stimulus: fetch_req and dbg_req held high continuously.
  - Required: grants in order fetch, fetch, fetch, fetch, dbg, fetch, ...
  - Required: dbg_valid exactly 2 cycles after its ready; no dbg_valid earlier.
- Req withdrawn: dbg_req pulsed high for one cycle while an access is in flight (state READ) -> no dbg_ready, no dbg access later.
- Reset mid-op: reset asserted in the READ cycle of a fetch to 0x00008 -> no fetch_valid; fetch_data=0 and state IDLE next cycle.
- ROM_ALIGN_CHECK_EN:
  - dbg_addr=0x00006 -> dbg_valid at T+2 with dbg_err=1 and dbg_data=0.
  - Without the macro, the same stimulus returns ROM word1 with dbg_err=0.
